// File: rtl/arb3_rr_if.sv
// Request/grant bundle between the requesters and the arb3_rr round-robin arbiter.
interface arb3_rr_if;
  logic       REQ0, REQ1, REQ2;
  logic       GNT0, GNT1, GNT2;
  logic       GV;
  logic [1:0] GID;

  modport master (output REQ0, REQ1, REQ2, input GNT0, GNT1, GNT2, GV, GID);
  modport slave  (input REQ0, REQ1, REQ2, output GNT0, GNT1, GNT2, GV, GID);
endinterface

// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with registered one-hot grants, grant hold
// until release, and an optional time-slice quantum (0 = unlimited).
module arb3_rr #(
  parameter int unsigned QUANTUM = 0
) (
  input  logic      CK,
  input  logic      CD,
  input  logic      CE,
  arb3_rr_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam bit         QEN   = (QUANTUM != 0);
  localparam logic [7:0] QLAST = (QUANTUM == 0) ? 8'd0 : 8'(QUANTUM - 1);

  state_t     state_q;
  logic [1:0] ptr_q, own_q;
  logic [7:0] cnt_q;
  logic [2:0] gnt_q;
  logic       gv_q;

  logic [3:0] req;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       rel;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] x);
    case (x)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Index 3 is never a legal owner; padding keeps the 2-bit select in range.
  assign req = {1'b0, bus.REQ2, bus.REQ1, bus.REQ0};

  // First requester found scanning PTR, PTR+1, PTR+2 (mod 3).
  always_comb begin
    logic [1:0] idx;
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
      idx = inc3(idx);
    end
  end

  assign rel = !req[own_q] || (QEN && (cnt_q == QLAST));

  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 3'b000;
      gv_q    <= 1'b0;
    end else if (CE) begin
      if ((state_q == IDLE || rel) && win_vld) begin
        // PTR already sits past the owner, so a lone expiring owner re-wins last.
        state_q <= GRANT;
        own_q   <= win_idx;
        ptr_q   <= inc3(win_idx);
        cnt_q   <= 8'd0;
        gnt_q   <= onehot3(win_idx);
        gv_q    <= 1'b1;
      end else if (state_q == GRANT && !rel) begin
        cnt_q <= (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
      end else begin
        state_q <= IDLE;
        gnt_q   <= 3'b000;
        gv_q    <= 1'b0;
      end
    end
  end

  assign bus.GNT0 = gnt_q[0];
  assign bus.GNT1 = gnt_q[1];
  assign bus.GNT2 = gnt_q[2];
  assign bus.GV   = gv_q;
  assign bus.GID  = own_q;

endmodule

// File: tb/tb_arb3_rr.sv
// Directed bench for arb3_rr: a vector table on a QUANTUM=0 instance plus
// hand sequences on QUANTUM=3, 2 and 1 instances.
module tb_arb3_rr;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic cd0, ce0, cd3, cd2, cd1;
  int   tests = 0;
  int   fails = 0;

  arb3_rr_if b0 ();
  arb3_rr_if b3 ();
  arb3_rr_if b2 ();
  arb3_rr_if b1 ();

  arb3_rr #(.QUANTUM(0)) u_q0 (.CK(CK), .CD(cd0), .CE(ce0),  .bus(b0));
  arb3_rr #(.QUANTUM(3)) u_q3 (.CK(CK), .CD(cd3), .CE(1'b1), .bus(b3));
  arb3_rr #(.QUANTUM(2)) u_q2 (.CK(CK), .CD(cd2), .CE(1'b1), .bus(b2));
  arb3_rr #(.QUANTUM(1)) u_q1 (.CK(CK), .CD(cd1), .CE(1'b1), .bus(b1));

  typedef struct packed {
    logic       cd;
    logic       ce;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       gv;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [2:0] g, input logic v, input logic [1:0] id,
                     input logic [2:0] eg, input logic ev, input logic [1:0] eid);
    tests++;
    if ({g, v, id} !== {eg, ev, eid}) begin
      fails++;
      $display("FAIL %s: got gnt=%b gv=%b gid=%0d, want gnt=%b gv=%b gid=%0d",
               nm, g, v, id, eg, ev, eid);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [1:0] gid_of(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  initial begin
    logic [2:0] exp3 [10];
    logic [2:0] exp1 [6];

    // cd ce req gnt gv gid
    tbl[0]  = '{1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0}; // reset with all requesting
    tbl[1]  = '{1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 3'b111, 3'b001, 1'b1, 2'd0}; // first grant from PTR=0
    tbl[3]  = '{1'b0, 1'b1, 3'b111, 3'b001, 1'b1, 2'd0}; // unlimited hold
    tbl[4]  = '{1'b0, 1'b1, 3'b110, 3'b010, 1'b1, 2'd1}; // owner drops -> 1, no gap
    tbl[5]  = '{1'b0, 1'b1, 3'b101, 3'b100, 1'b1, 2'd2};
    tbl[6]  = '{1'b0, 1'b1, 3'b011, 3'b001, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0}; // idle, GID kept
    tbl[8]  = '{1'b0, 1'b1, 3'b100, 3'b100, 1'b1, 2'd2}; // PTR=1, REQ1 absent -> 2
    tbl[9]  = '{1'b0, 1'b1, 3'b100, 3'b100, 1'b1, 2'd2};
    tbl[10] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2}; // CE freeze while REQ2 drops
    tbl[11] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 2'd2};
    tbl[14] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd2}; // release after CE returns
    tbl[15] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[16] = '{1'b0, 1'b1, 3'b001, 3'b001, 1'b1, 2'd0}; // 3-cycle REQ0 pulse
    tbl[17] = '{1'b0, 1'b1, 3'b001, 3'b001, 1'b1, 2'd0};
    tbl[18] = '{1'b0, 1'b1, 3'b001, 3'b001, 1'b1, 2'd0};
    tbl[19] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[20] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[21] = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 2'd0}; // CE=0 ignores requests
    tbl[22] = '{1'b0, 1'b1, 3'b100, 3'b100, 1'b1, 2'd2}; // PTR=1 after grant 0
    tbl[23] = '{1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 2'd0}; // reset overrides CE=0

    cd0 = 1'b1; ce0 = 1'b1; cd3 = 1'b1; cd2 = 1'b1; cd1 = 1'b1;
    {b0.REQ2, b0.REQ1, b0.REQ0} = 3'b000;
    {b3.REQ2, b3.REQ1, b3.REQ0} = 3'b000;
    {b2.REQ2, b2.REQ1, b2.REQ0} = 3'b000;
    {b1.REQ2, b1.REQ1, b1.REQ0} = 3'b000;
    tick();

    for (int i = 0; i < 24; i++) begin
      cd0 = tbl[i].cd;
      ce0 = tbl[i].ce;
      {b0.REQ2, b0.REQ1, b0.REQ0} = tbl[i].req;
      tick();
      chk($sformatf("q0_vec%0d", i), {b0.GNT2, b0.GNT1, b0.GNT0}, b0.GV, b0.GID,
          tbl[i].gnt, tbl[i].gv, tbl[i].gid);
    end

    // QUANTUM=3, constant 111: three cycles each in rotation.
    exp3 = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
    chk("q3_reset", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b000, 1'b0, 2'd0);
    cd3 = 1'b0;
    {b3.REQ2, b3.REQ1, b3.REQ0} = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("q3_rot%0d", i), {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID,
          exp3[i], 1'b1, gid_of(exp3[i]));
    end
    tick();
    chk("q3_hold", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b001, 1'b1, 2'd0);
    tick();
    chk("q3_hold2", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b001, 1'b1, 2'd0);
    tick(); // owner 0 expires -> 1
    chk("q3_pre_rst", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b010, 1'b1, 2'd1);
    cd3 = 1'b1;
    tick();
    chk("q3_midrst", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b000, 1'b0, 2'd0);
    cd3 = 1'b0;
    tick();
    chk("q3_postrst", {b3.GNT2, b3.GNT1, b3.GNT0}, b3.GV, b3.GID, 3'b001, 1'b1, 2'd0);

    // QUANTUM=2, sole requester 1 keeps the grant across expiries.
    cd2 = 1'b0;
    {b2.REQ2, b2.REQ1, b2.REQ0} = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("q2_sole%0d", i), {b2.GNT2, b2.GNT1, b2.GNT0}, b2.GV, b2.GID,
          3'b010, 1'b1, 2'd1);
    end
    // Five edges: grant at 1, re-grants at 3 and 5, so CNT=0 now.
    b2.REQ2 = 1'b1;
    tick();
    chk("q2_wait", {b2.GNT2, b2.GNT1, b2.GNT0}, b2.GV, b2.GID, 3'b010, 1'b1, 2'd1);
    tick();
    chk("q2_hand", {b2.GNT2, b2.GNT1, b2.GNT0}, b2.GV, b2.GID, 3'b100, 1'b1, 2'd2);

    // QUANTUM=1: strict one-cycle rotation.
    exp1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    cd1 = 1'b0;
    {b1.REQ2, b1.REQ1, b1.REQ0} = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("q1_rot%0d", i), {b1.GNT2, b1.GNT1, b1.GNT0}, b1.GV, b1.GID,
          exp1[i], 1'b1, gid_of(exp1[i]));
    end
    {b1.REQ2, b1.REQ1, b1.REQ0} = 3'b000;
    tick();
    chk("q1_idle", {b1.GNT2, b1.GNT1, b1.GNT0}, b1.GV, b1.GID, 3'b000, 1'b0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
